// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// error codes and an access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // Number of bytes touched by an access of encoded size 0..3.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request decode (lane mask, store shift, alignment,
// legality) and load-side extract plus sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(LANES)
) (
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata,
  output logic [LANES-1:0]  lane_mask,
  output logic [DATA_W-1:0] store_data,
  output logic              misaligned,
  output logic              illegal,
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  ld_offset,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic [DATA_W-1:0] load_data
);

  logic [3:0]       nbytes;
  logic [LANES-1:0] base_mask;

  assign nbytes = size_bytes(funct3[1:0]);

  always_comb begin
    base_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      base_mask[i] = (i < int'(nbytes));
    end
  end

  assign lane_mask  = base_mask << offset;
  assign store_data = wdata << {offset, 3'b000};
  assign misaligned = (4'(offset) & (nbytes - 4'd1)) != 4'd0;

  // Doubleword accesses only exist when the data path is 64 bits wide.
  assign illegal = (funct3 == 3'b111) ||
                   ((DATA_W == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)));

  always_comb begin
    logic [DATA_W-1:0] shifted;
    logic              sign;
    int                nbits;
    shifted   = rdata >> {ld_offset, 3'b000};
    nbits     = 8 << ld_size;
    sign      = 1'b0;
    load_data = '0;
    case (ld_size)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[DATA_W-1];
    endcase
    if (ld_unsigned) begin
      sign = 1'b0;
    end
    for (int i = 0; i < DATA_W; i++) begin
      load_data[i] = (i < nbits) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and the data-memory port: one request per
// handshake, single-cycle stores, loads wait for read data with a timeout.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 32,
  parameter  int TIMEOUT = 15,
  localparam int LANES   = DATA_W / 8,
  localparam int OFF_W   = $clog2(LANES)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [ADDR_W-1:0] d_addr_o,
  output logic [DATA_W-1:0] d_wdata_o,
  output logic [LANES-1:0]  d_we_o,
  output logic [LANES-1:0]  d_rd_o,
  input  logic              d_rvalid_i,
  input  logic [DATA_W-1:0] d_rdata_i,
  output logic              load_ready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              store_done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  state_t state, next_state;

  logic              idle_ok, accept, req_ok, store_go, load_go, timed_out;
  logic [LANES-1:0]  lane_mask;
  logic [DATA_W-1:0] store_data, load_data;
  logic              misaligned, illegal;
  logic [ADDR_W-1:0] aligned_addr;

  logic [OFF_W-1:0]  ld_offset;
  logic [1:0]        ld_size;
  logic              ld_unsigned;
  logic [LANES-1:0]  ld_mask;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q, store_done_q;
  logic [1:0]        err_code_q;

  // Qualifying with rst_n_i keeps every output quiet while reset is held.
  assign idle_ok      = (state == IDLE) && rst_n_i;
  assign accept       = req_valid_i && idle_ok;
  assign req_ok       = accept && !illegal && !misaligned;
  assign store_go     = req_ok && req_we_i;
  assign load_go      = req_ok && !req_we_i;
  assign timed_out    = (cnt == 8'(TIMEOUT - 1));
  assign aligned_addr = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .funct3     (funct3_i),
    .offset     (addr_i[OFF_W-1:0]),
    .wdata      (wdata_i),
    .lane_mask  (lane_mask),
    .store_data (store_data),
    .misaligned (misaligned),
    .illegal    (illegal),
    .rdata      (d_rdata_i),
    .ld_offset  (ld_offset),
    .ld_size    (ld_size),
    .ld_unsigned(ld_unsigned),
    .load_data  (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_go) next_state = RD_WAIT;
      RD_WAIT: begin
        if (d_rvalid_i) begin
          next_state = RESP;
        end else if (timed_out) begin
          next_state = IDLE;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = idle_ok;
    load_ready_o = (state == RESP);
    d_we_o       = '0;
    d_rd_o       = '0;
    d_addr_o     = '0;
    d_wdata_o    = '0;
    case (state)
      IDLE: begin
        if (store_go) begin
          d_we_o    = lane_mask;
          d_wdata_o = store_data;
          d_addr_o  = aligned_addr;
        end else if (load_go) begin
          d_rd_o    = lane_mask;
          d_addr_o  = aligned_addr;
        end
      end
      RD_WAIT: begin
        d_rd_o   = ld_mask;
        d_addr_o = ld_addr;
      end
      default: ;
    endcase
  end

  // A read response arriving on the final allowed cycle still beats the timeout.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ld_offset    <= '0;
      ld_size      <= '0;
      ld_unsigned  <= 1'b0;
      ld_mask      <= '0;
      ld_addr      <= '0;
      cnt          <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      store_done_q <= 1'b0;
    end else begin
      err_q        <= 1'b0;
      store_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_ILLEGAL;
            end else if (misaligned) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_MISALIGN;
            end else if (req_we_i) begin
              store_done_q <= 1'b1;
            end else begin
              ld_offset   <= addr_i[OFF_W-1:0];
              ld_size     <= funct3_i[1:0];
              ld_unsigned <= funct3_i[2];
              ld_mask     <= lane_mask;
              ld_addr     <= aligned_addr;
              cnt         <= '0;
            end
          end
        end
        RD_WAIT: begin
          if (d_rvalid_i) begin
            rdata_q <= load_data;
          end else if (timed_out) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            rdata_q    <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata_o      = rdata_q;
  assign store_done_o = store_done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Parametrised, sequential load/store unit between the core's execute stage and the data-memory port.
- Accepts one load/store request per handshake.
- Generates byte-lane write/read enables and shifts store data onto lanes.
- Waits a variable number of cycles for memory read data, then extracts, sign- or zero-extends and returns the load result with a ready pulse.
- Flags misaligned accesses and memory timeouts instead of issuing them.

Parameters:
DATA_W, 32, memory/data width in bits; legal 32 or 64. LANES = DATA_W/8.
ADDR_W, 32, byte-address width.
TIMEOUT, 15, max cycles waiting for d_rvalid_i before error; legal 1..255.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  unit can accept a request (high only in IDLE)
req_we_i  in  1  1 = store, 0 = load
funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (DATA_W=64 only)
addr_i  in  ADDR_W  byte address
wdata_i  in  DATA_W  store data, right-aligned
d_addr_o  out  ADDR_W  memory address, low log2(LANES) bits forced to 0
d_wdata_o  out  DATA_W  store data shifted to lane position
d_we_o  out  LANES  byte write enables
d_rd_o  out  LANES  byte read enables
d_rvalid_i  in  1  memory read data valid
d_rdata_i  in  DATA_W  memory read data
load_ready_o  out  1  one-cycle pulse: rdata_o valid
rdata_o  out  DATA_W  extended load result
store_done_o  out  1  one-cycle pulse: store issued
err_o  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout
err_code_o  out  2  01 misaligned, 10 timeout, 11 illegal funct3; held until next err_o

Behaviour:
Reset (rst_n_i low, async): state IDLE, all outputs 0, timeout counter 0. Mid-transaction reset abandons the access; no pulse after release.

FSM states: IDLE, RD_WAIT, RESP.

IDLE
- req_ready_o = 1.
- Handshake occurs when req_valid_i && req_ready_o.
- On handshake, decode combinationally in the same cycle:
  - size = funct3_i[1:0].
  - Misaligned when (addr & (size_bytes-1)) != 0.
- Illegal funct3 (111; 011/110 when DATA_W=32), or misaligned:
  - registered err_o pulse next cycle with the code; illegal takes priority over misaligned.
  - no d_we_o/d_rd_o asserted; stay in IDLE.
- Legal store:
  - d_we_o = ((1<<size_bytes)-1) << addr[lsb].
  - d_wdata_o = wdata_i << (8*addr[lsb]).
  - d_addr_o set; all driven for exactly that one cycle (combinational from the request).
  - store_done_o pulses the next cycle; stay in IDLE (back-to-back stores at 1/cycle).
- Legal load:
  - register address offset, size and signedness.
  - drive d_rd_o mask and d_addr_o, holding them through RD_WAIT.
  - go to RD_WAIT, counter = 0.

RD_WAIT
- req_ready_o = 0.
- Each cycle without d_rvalid_i, counter++.
- d_rvalid_i: capture d_rdata_i >> (8*offset), mask to size, extend (sign from top bit of the sized field unless unsigned), load into rdata_o; go to RESP.
- Counter reaching TIMEOUT with no d_rvalid_i: err_o pulse, code 10, rdata_o = 0, go to IDLE.
- d_rvalid_i in the same cycle the counter hits TIMEOUT: data wins, no error.
- d_rvalid_i outside RD_WAIT is ignored.

RESP
- load_ready_o = 1 for one cycle; rdata_o holds its value until the next load completes.
- Then IDLE.
- Minimum load latency: handshake at cycle N, d_rvalid_i at N+1, load_ready_o at N+2.

Outputs d_we_o and d_rd_o are never both nonzero.

Decomposition:
- Shared package lsu_pkg:
  - funct3 encodings F3_B/H/W/D/BU/HU/WU.
  - state encoding (IDLE, RD_WAIT, RESP).
  - error codes ERR_MISALIGN/TIMEOUT/ILLEGAL.
- One natural sub-module: lsu_align, purely combinational:
  - computes lane masks, store shift, misalignment and illegal flags from funct3/addr.
  - load extract/extend from rdata/offset/size/signed.
  - reused by a future cache path.

Test Plan:
- DATA_W=32, SB addr 0x1003, wdata 0xAB -> d_we_o 1000, d_wdata_o 0xAB000000, d_addr_o 0x1000, store_done_o next cycle.
- LH addr 0x2002, d_rvalid_i 2 cycles later with d_rdata_i 0x8001_1234 -> load_ready_o pulse, rdata_o 0xFFFF8001; LHU same -> 0x00008001.
- LW addr 0x0006 -> err_o pulse, err_code_o 01, d_rd_o stays 0, req_ready_o stays 1.
- TIMEOUT=3, LB with d_rvalid_i never asserted -> err_o code 10 three cycles into RD_WAIT, then IDLE, no load_ready_o.
- DATA_W=64, LD addr 0x8 with d_rdata_i 0x0123456789ABCDEF -> d_rd_o 0xFF, rdata_o 0x0123456789ABCDEF; LWU addr 0xC -> 0x01234567.
- rst_n_i low while in RD_WAIT, then d_rvalid_i after release -> no load_ready_o, all outputs 0, req_ready_o 1.
